speed_test_sequencer: RTL and testbench

//  Timed test-run sequencer between the speed-test register block and the per-port frame generators/checkers.

---
 rtl/speed_test_sequencer_if.sv | 34 +++
 rtl/speed_test_sequencer.sv | 164 ++++++++++++++++
 tb/tb_speed_test_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/speed_test_sequencer_if.sv
// Handshake and per-port status bundle between the speed-test register block, the sequencer
// and the frame generators/checkers.
interface speed_test_sequencer_if #(
    parameter int unsigned TEST_PORT_NUM = 4
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [TEST_PORT_NUM-1:0]       cmd_port_mask;
    logic [31:0]                    cmd_duration;
    logic                           abort;
    logic [TEST_PORT_NUM-1:0]       gen_ready;
    logic [TEST_PORT_NUM-1:0]       check_ready;
    logic [TEST_PORT_NUM*128-1:0]   check_results;
    logic [TEST_PORT_NUM-1:0]       start;
    logic [TEST_PORT_NUM-1:0]       stop;
    logic                           busy;
    logic                           done;
    logic [1:0]                     status;
    logic [31:0]                    elapsed;
    logic [TEST_PORT_NUM*128-1:0]   results;

    // Environment side: register block plus generators/checkers.
    modport master (
        output cmd_valid, cmd_port_mask, cmd_duration, abort, gen_ready, check_ready,
               check_results,
        input  cmd_ready, start, stop, busy, done, status, elapsed, results
    );

    modport slave (
        input  cmd_valid, cmd_port_mask, cmd_duration, abort, gen_ready, check_ready,
               check_results,
        output cmd_ready, start, stop, busy, done, status, elapsed, results
    );
endinterface

// File: rtl/speed_test_sequencer.sv
// Timed test-run sequencer: accepts one run command, starts the selected ports, times the run
// in TICK_HZ ticks, stops the ports, waits for the checkers to drain and snapshots results.
module speed_test_sequencer #(
    parameter int unsigned TEST_PORT_NUM        = 4,
    parameter int unsigned CLOCK_FREQ           = 125000000,
    parameter int unsigned TICK_HZ              = 1000,
    parameter int unsigned READY_TIMEOUT_CYCLES = 1000000
) (
    input logic                    clk,
    input logic                    rst,
    speed_test_sequencer_if.slave  bus_io
);

    localparam int unsigned PreCycles = CLOCK_FREQ / TICK_HZ;
    localparam int unsigned PreW      = (PreCycles > 1) ? $clog2(PreCycles) : 1;
    localparam int unsigned TmoW      = $clog2(READY_TIMEOUT_CYCLES + 1);
    localparam logic [PreW-1:0] PreLast = PreW'(PreCycles - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(READY_TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StatusOk      = 2'd0;
    localparam logic [1:0] StatusBadCmd  = 2'd1;
    localparam logic [1:0] StatusTimeout = 2'd2;
    localparam logic [1:0] StatusAborted = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StWaitReady, StStart, StRun, StStop, StDrain, StDone
    } state_e;

    state_e                       state_q;
    logic                         cmd_ready_q;
    logic [TEST_PORT_NUM-1:0]     mask_q;
    logic [31:0]                  dur_q;
    logic [PreW-1:0]              pre_q;
    logic [TmoW-1:0]              tmo_q;
    logic [TEST_PORT_NUM-1:0]     start_q;
    logic [TEST_PORT_NUM-1:0]     stop_q;
    logic                         busy_q;
    logic                         done_q;
    logic [1:0]                   status_q;
    logic [31:0]                  elapsed_q;
    logic [TEST_PORT_NUM*128-1:0] results_q;

    logic [31:0] elapsed_inc;
    logic        all_ready;
    logic        drain_ready;
    logic        tick_wrap;

    assign elapsed_inc = elapsed_q + 32'd1;
    assign all_ready   = ((bus_io.gen_ready & bus_io.check_ready & mask_q) == mask_q);
    assign drain_ready = ((bus_io.check_ready & mask_q) == mask_q);
    assign tick_wrap   = (pre_q == PreLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            mask_q      <= '0;
            dur_q       <= '0;
            pre_q       <= '0;
            tmo_q       <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= StatusOk;
            elapsed_q   <= '0;
            results_q   <= '0;
        end else begin
            start_q <= '0;
            stop_q  <= '0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_ready_q && bus_io.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        elapsed_q   <= '0;
                        mask_q      <= bus_io.cmd_port_mask;
                        dur_q       <= bus_io.cmd_duration;
                        tmo_q       <= '0;
                        if (bus_io.cmd_port_mask == '0 || bus_io.cmd_duration == 32'd0) begin
                            status_q <= StatusBadCmd;
                            state_q  <= StDone;
                        end else begin
                            status_q <= StatusOk;
                            state_q  <= StWaitReady;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                // Ready takes priority over abort and timeout in the same cycle.
                StWaitReady: begin
                    if (all_ready) begin
                        state_q <= StStart;
                    end else if (bus_io.abort) begin
                        status_q <= StatusAborted;
                        state_q  <= StDone;
                    end else if (tmo_q == TmoLast) begin
                        status_q <= StatusTimeout;
                        state_q  <= StDone;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StStart: begin
                    start_q <= mask_q;
                    pre_q   <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    if (tick_wrap) begin
                        pre_q     <= '0;
                        elapsed_q <= elapsed_inc;
                    end else begin
                        pre_q <= pre_q + PreW'(1);
                    end
                    // A final tick coinciding with abort completes as OK.
                    if (tick_wrap && elapsed_inc == dur_q) begin
                        state_q <= StStop;
                    end else if (bus_io.abort) begin
                        status_q <= StatusAborted;
                        state_q  <= StStop;
                    end
                end
                StStop: begin
                    stop_q  <= mask_q;
                    tmo_q   <= '0;
                    state_q <= StDrain;
                end
                StDrain: begin
                    if (drain_ready || tmo_q == TmoLast) begin
                        for (int i = 0; i < int'(TEST_PORT_NUM); i++) begin
                            results_q[128*i +: 128] <= mask_q[i] ?
                                bus_io.check_results[128*i +: 128] : 128'd0;
                        end
                        if (!drain_ready) begin
                            status_q <= StatusTimeout;
                        end
                        state_q <= StDone;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.cmd_ready = cmd_ready_q;
    assign bus_io.start     = start_q;
    assign bus_io.stop      = stop_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
    assign bus_io.status    = status_q;
    assign bus_io.elapsed   = elapsed_q;
    assign bus_io.results   = results_q;

endmodule

// File: tb/tb_speed_test_sequencer.sv
// Scoreboard bench for speed_test_sequencer: stimulus queues the expected run outcome, a monitor
// checks every done pulse against it along with start/stop pulse counts and latencies.
module tb_speed_test_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned CF = 1000;
    localparam int unsigned TH = 100;
    localparam int unsigned TO = 50;

    localparam logic [511:0] CR_A = {{4{32'h44444444}}, {4{32'h33333333}},
                                     {4{32'h22222222}}, {4{32'h11111111}}};
    localparam logic [511:0] CR_B = {{4{32'hDDDDDDDD}}, {4{32'hCCCCCCCC}},
                                     {4{32'hBBBBBBBB}}, {4{32'hAAAAAAAA}}};
    localparam logic [511:0] CR_C = {{4{32'hFFFFFFFF}}, {4{32'hEEEEEEEE}},
                                     {4{32'h99999999}}, {4{32'h88888888}}};
    localparam logic [511:0] R1   = {128'h0, {4{32'h33333333}}, 128'h0, {4{32'h11111111}}};
    localparam logic [511:0] R5A  = {384'h0, {4{32'hAAAAAAAA}}};
    localparam logic [511:0] R5B  = {384'h0, {4{32'h88888888}}};
    localparam logic [511:0] R6   = {{4{32'h44444444}}, 384'h0};

    typedef struct {
        logic [1:0]   status;
        logic [31:0]  elapsed;
        logic [511:0] results;
        logic [3:0]   pulse;      // expected start/stop mask, 0 = no pulses
        int           start_dly;  // start edge - accept edge
        int           run_dly;    // stop edge - start edge, -1 = not checked
        int           done_dly;   // done edge - stop edge, or - accept edge when no pulses
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    exp_t       exp_q[$];
    exp_t       e;
    int         acc_cyc = 0;
    int         start_cyc = 0;
    int         stop_cyc = 0;
    int         n_start = 0;
    int         n_stop = 0;
    logic [3:0] start_val = '0;
    logic [3:0] stop_val = '0;

    speed_test_sequencer_if #(.TEST_PORT_NUM(N)) bus ();

    speed_test_sequencer #(
        .TEST_PORT_NUM       (N),
        .CLOCK_FREQ          (CF),
        .TICK_HZ             (TH),
        .READY_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    endtask

    function automatic exp_t mk(input logic [1:0] st, input logic [31:0] el,
                                input logic [511:0] res, input logic [3:0] pl,
                                input int sd, input int rd, input int dd);
        exp_t x;
        x.status = st; x.elapsed = el; x.results = res; x.pulse = pl;
        x.start_dly = sd; x.run_dly = rd; x.done_dly = dd;
        return x;
    endfunction

    // Monitor: samples on the falling edge; cyc then equals the index of the last rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc = cyc + 1;
                n_start = 0;
                n_stop  = 0;
            end
            if (bus.start != '0) begin
                n_start++; start_cyc = cyc; start_val = bus.start;
                chk("busy_at_start", bus.busy, 1);
            end
            if (bus.stop != '0) begin
                n_stop++; stop_cyc = cyc; stop_val = bus.stop;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("status", bus.status, e.status);
                    chk("elapsed", bus.elapsed, e.elapsed);
                    chk("results", bus.results, e.results);
                    if (e.pulse != '0) begin
                        chk("start_count", n_start, 1);
                        chk("stop_count", n_stop, 1);
                        chk("start_mask", start_val, e.pulse);
                        chk("stop_mask", stop_val, e.pulse);
                        chk("start_latency", start_cyc - acc_cyc, e.start_dly);
                        if (e.run_dly >= 0) chk("run_length", stop_cyc - start_cyc, e.run_dly);
                        chk("drain_latency", cyc - stop_cyc, e.done_dly);
                    end else begin
                        chk("start_count", n_start, 0);
                        chk("stop_count", n_stop, 0);
                        chk("done_latency", cyc - acc_cyc, e.done_dly);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] m, input logic [31:0] d, input exp_t x);
        int k = 0;
        while (!bus.cmd_ready && k < 200) begin tick(); k++; end
        if (!bus.cmd_ready) chk("cmd_ready_wait", 0, 1);
        exp_q.push_back(x);
        bus.cmd_valid = 1'b1; bus.cmd_port_mask = m; bus.cmd_duration = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin tick(); k++; end
        if (exp_q.size() != 0) begin
            chk(nm, 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic wait_stop(input string nm);
        int k = 0;
        while (bus.stop == '0 && k < 2000) begin tick(); k++; end
        if (bus.stop == '0) chk(nm, 0, 1);
    endtask

    task automatic wait_elapsed(input string nm, input logic [31:0] v);
        int k = 0;
        while (bus.elapsed != v && k < 2000) begin tick(); k++; end
        if (bus.elapsed != v) chk(nm, bus.elapsed, v);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {bus.cmd_ready, bus.start, bus.stop, bus.busy, bus.done, bus.status,
                 bus.elapsed, bus.results[447:0]}, 0);
        chk({nm, "_results_hi"}, bus.results[511:448], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_port_mask = '0; bus.cmd_duration = '0;
        bus.abort = 1'b0; bus.gen_ready = 4'hF; bus.check_ready = 4'hF;
        bus.check_results = CR_A;

        // Reset state and release
        tick(); tick();
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        chk("cmd_ready_at_release", bus.cmd_ready, 0);
        tick();
        chk("cmd_ready_after_release", bus.cmd_ready, 1);

        // 1: normal run; 10 cycles/tick -> stop 31 edges after start (30 after start falls)
        issue(4'b0101, 32'd3, mk(2'd0, 32'd3, R1, 4'b0101, 2, 31, 2));
        wait_done("t1_done");

        // 2: bad commands leave results untouched
        issue(4'b0000, 32'd5, mk(2'd1, 32'd0, R1, 4'b0000, 0, -1, 1));
        wait_done("t2a_done");
        issue(4'b0011, 32'd0, mk(2'd1, 32'd0, R1, 4'b0000, 0, -1, 1));
        wait_done("t2b_done");

        // 3: generator 2 never ready -> timeout after 50 cycles in WAIT_READY
        bus.gen_ready = 4'b1011;
        issue(4'b0100, 32'd4, mk(2'd2, 32'd0, R1, 4'b0000, 0, -1, 51));
        wait_done("t3_done");
        bus.gen_ready = 4'hF;

        // Abort while idle has no effect
        bus.abort = 1'b1;
        tick(); tick(); tick();
        chk("idle_abort_busy", bus.busy, 0);
        chk("idle_abort_ready", bus.cmd_ready, 1);
        bus.abort = 1'b0;

        // 4: abort at tick 5 of a 100-tick run
        issue(4'b1111, 32'd100, mk(2'd3, 32'd5, CR_A, 4'b1111, 2, -1, 2));
        wait_elapsed("t4_elapsed_wait", 32'd5);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        wait_done("t4_done");

        // 5a: checker busy 20 cycles after stop, abort during drain ignored
        bus.check_results = CR_B;
        issue(4'b0001, 32'd1, mk(2'd0, 32'd1, R5A, 4'b0001, 2, 11, 22));
        wait_stop("t5a_stop_wait");
        bus.check_ready = 4'h0; bus.abort = 1'b1;
        repeat (20) tick();
        bus.check_ready = 4'hF; bus.abort = 1'b0;
        wait_done("t5a_done");

        // 5b: checker busy 60 cycles -> drain timeout, results still latched
        bus.check_results = CR_C;
        issue(4'b0001, 32'd1, mk(2'd2, 32'd1, R5B, 4'b0001, 2, 11, 51));
        wait_stop("t5b_stop_wait");
        bus.check_ready = 4'h0;
        repeat (60) tick();
        bus.check_ready = 4'hF;
        wait_done("t5b_done");

        // 6: reset mid-run, then a clean run
        bus.check_results = CR_A;
        issue(4'b0010, 32'd10, mk(2'd0, 32'd10, 512'h0, 4'b0010, 2, 101, 2));
        wait_elapsed("t6_elapsed_wait", 32'd2);
        rst = 1'b1;
        #1;
        chk_all_zero("midrun_reset");
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("cmd_ready_at_release2", bus.cmd_ready, 0);
        tick();
        chk("cmd_ready_after_release2", bus.cmd_ready, 1);
        issue(4'b1000, 32'd2, mk(2'd0, 32'd2, R6, 4'b1000, 2, 21, 2));
        wait_done("t6_done");

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
